// File: rtl/vote_tally_param.sv
// Parametrised ballot counter: saturating per-candidate tallies, sticky poll close,
// edge-stepped result browsing and a one-candidate-per-cycle winner/tie scan.
module vote_tally_param #(
  parameter int N_CAND = 15,
  parameter int ID_W   = 4,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             Power,
  input  logic             Clear,
  input  logic             Close,
  input  logic             Ballot,
  input  logic             Total,
  input  logic             Result,
  input  logic             Winner,
  input  logic [ID_W-1:0]  IN,
  output logic [CNT_W-1:0] out,
  output logic [ID_W-1:0]  out_idx,
  output logic             vote_ack,
  output logic             vote_err,
  output logic             busy,
  output logic             tie
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_TOTAL, S_CLOSED, S_RESULT, S_SCAN, S_WIN, S_CLEAR
  } state_t;

  localparam int               DEPTH    = 2 ** ID_W;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_CAND);
  localparam logic [ID_W-1:0]  FIRST_ID = ID_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tally_q [DEPTH];
  logic [CNT_W-1:0] total_q;
  logic [ID_W-1:0]  idx_q, idx_d;
  logic [ID_W-1:0]  scan_q, scan_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [ID_W-1:0]  best_id_q, best_id_d;
  logic             tie_q, tie_d;
  logic             result_q;
  logic             lock_q;
  logic [CNT_W-1:0] out_q, out_d;
  logic [ID_W-1:0]  out_idx_q, out_idx_d;

  logic             rise;
  logic             in_valid;
  logic             in_bad;
  logic             count_en;
  logic [CNT_W-1:0] scan_cnt;

  assign rise     = Result & ~result_q;
  assign in_valid = (IN != '0) && (IN <= LAST_ID);
  assign in_bad   = (IN > LAST_ID);
  assign count_en = (state_q == S_ARMED) && !Close && in_valid;
  assign scan_cnt = tally_q[scan_q];

  assign vote_ack = count_en && !Power;
  assign vote_err = (state_q == S_ARMED) && !Close && in_bad && !Power;
  assign busy     = (state_q == S_SCAN);
  assign tie      = (state_q == S_WIN) && tie_q;
  assign out      = out_q;
  assign out_idx  = out_idx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    scan_d     = scan_q;
    best_cnt_d = best_cnt_q;
    best_id_d  = best_id_q;
    tie_d      = tie_q;
    out_d      = out_q;
    out_idx_d  = out_idx_q;

    // Display register follows the state held during this cycle
    case (state_q)
      S_IDLE, S_CLEAR: begin
        out_d     = '0;
        out_idx_d = '0;
      end
      S_TOTAL: begin
        out_d     = total_q;
        out_idx_d = '0;
      end
      S_RESULT: begin
        out_d     = tally_q[idx_q];
        out_idx_d = idx_q;
      end
      S_WIN: begin
        out_d     = best_cnt_q;
        out_idx_d = best_id_q;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (Clear)                 state_d = S_CLEAR;
        else if (Close)            state_d = S_CLOSED;
        else if (Ballot && !lock_q) state_d = S_ARMED;
        else if (Total)            state_d = S_TOTAL;
      end
      S_ARMED: begin
        if (Close)         state_d = S_CLOSED;
        else if (in_valid) state_d = S_IDLE;
      end
      S_TOTAL: begin
        if (Clear)       state_d = S_CLEAR;
        else if (Close)  state_d = S_CLOSED;
        else if (Ballot) state_d = S_IDLE;
      end
      S_CLOSED, S_RESULT: begin
        if (Clear) begin
          state_d = S_CLEAR;
        end else if (Winner) begin
          state_d    = S_SCAN;
          scan_d     = FIRST_ID;
          best_cnt_d = '0;
          best_id_d  = '0;
          tie_d      = 1'b0;
        end else if (rise) begin
          state_d = S_RESULT;
          if (state_q == S_RESULT)
            idx_d = (idx_q == LAST_ID) ? FIRST_ID : idx_q + FIRST_ID;
        end
      end
      S_SCAN: begin
        // Strict greater keeps the lowest ID among equal counts
        if (scan_cnt > best_cnt_q) begin
          best_cnt_d = scan_cnt;
          best_id_d  = scan_q;
          tie_d      = 1'b0;
        end else if ((scan_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
          tie_d = 1'b1;
        end
        if (scan_q == LAST_ID) state_d = S_WIN;
        else                   scan_d  = scan_q + FIRST_ID;
      end
      S_WIN: begin
        if (Clear)     state_d = S_CLEAR;
        else if (rise) state_d = S_RESULT;
      end
      S_CLEAR: begin
        idx_d = FIRST_ID;
        tie_d = 1'b0;
        if (!Clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Power) begin
      state_q    <= S_IDLE;
      idx_q      <= FIRST_ID;
      scan_q     <= FIRST_ID;
      best_cnt_q <= '0;
      best_id_q  <= '0;
      tie_q      <= 1'b0;
      result_q   <= 1'b0;
      lock_q     <= 1'b0;
      out_q      <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      scan_q     <= scan_d;
      best_cnt_q <= best_cnt_d;
      best_id_q  <= best_id_d;
      tie_q      <= tie_d;
      result_q   <= Result;
      out_q      <= out_d;
      out_idx_q  <= out_idx_d;
      // One vote per arming: a still-held Ballot must drop before it can re-arm
      if (count_en)     lock_q <= 1'b1;
      else if (!Ballot) lock_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Power || (state_q == S_CLEAR)) begin
      for (int i = 0; i < DEPTH; i++) tally_q[i] <= '0;
      total_q <= '0;
    end else if (count_en) begin
      if (tally_q[IN] != CNT_MAX) tally_q[IN] <= tally_q[IN] + CNT_W'(1);
      if (total_q != CNT_MAX)     total_q     <= total_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vote_tally_param.sv
// Bench for vote_tally_param: two instances (N_CAND=8/CNT_W=3 and N_CAND=15/CNT_W=12)
// share one stimulus stream and are checked every cycle against an abstract model.
module tb_vote_tally_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Power, Clear, Close, Ballot, Total, Result, Winner;
  logic [3:0] IN;

  logic [2:0]  out_a;
  logic [3:0]  idx_a;
  logic        ack_a, err_a, busy_a, tie_a;
  logic [11:0] out_b;
  logic [3:0]  idx_b;
  logic        ack_b, err_b, busy_b, tie_b;

  vote_tally_param #(.N_CAND(8), .ID_W(4), .CNT_W(3)) dut_a (
    .clk(clk), .Power(Power), .Clear(Clear), .Close(Close), .Ballot(Ballot),
    .Total(Total), .Result(Result), .Winner(Winner), .IN(IN),
    .out(out_a), .out_idx(idx_a), .vote_ack(ack_a), .vote_err(err_a),
    .busy(busy_a), .tie(tie_a)
  );

  vote_tally_param #(.N_CAND(15), .ID_W(4), .CNT_W(12)) dut_b (
    .clk(clk), .Power(Power), .Clear(Clear), .Close(Close), .Ballot(Ballot),
    .Total(Total), .Result(Result), .Winner(Winner), .IN(IN),
    .out(out_b), .out_idx(idx_b), .vote_ack(ack_b), .vote_err(err_b),
    .busy(busy_b), .tie(tie_b)
  );

  localparam int M_IDLE = 0, M_ARMED = 1, M_TOTAL = 2, M_CLOSED = 3;
  localparam int M_RESULT = 4, M_SCAN = 5, M_WIN = 6, M_CLEAR = 7;

  // Model: index 0 mirrors dut_a, index 1 mirrors dut_b
  int m_st[2], m_tally[2][16], m_total[2], m_idx[2], m_best[2], m_bid[2];
  int m_tie[2], m_left[2], m_lock[2], m_prev[2], m_out[2], m_oidx[2];

  int total_cnt = 0;
  int bad_cnt   = 0;
  bit chk_en    = 0;
  int ack_cnt_a = 0, err_cnt_a = 0, busy_cnt_a = 0, busy_cnt_b = 0;

  function automatic int ncand(input int d);
    return (d == 0) ? 8 : 15;
  endfunction

  function automatic int cmax(input int d);
    return (d == 0) ? 7 : 4095;
  endfunction

  // Winner is computed from the frozen tallies at scan start; the scan only costs time
  task automatic start_scan(input int d);
    int n, ties;
    n = ncand(d);
    m_best[d] = 0;
    m_bid[d]  = 0;
    for (int k = 1; k <= n; k++)
      if (m_tally[d][k] > m_best[d]) begin
        m_best[d] = m_tally[d][k];
        m_bid[d]  = k;
      end
    ties = 0;
    for (int k = 1; k <= n; k++)
      if (m_tally[d][k] == m_best[d]) ties++;
    m_tie[d]  = (m_best[d] > 0 && ties > 1) ? 1 : 0;
    m_left[d] = n;
    m_st[d]   = M_SCAN;
  endtask

  task automatic model_step(input int d);
    int n, cm, id, rise, voted;
    n  = ncand(d);
    cm = cmax(d);
    id = int'(IN);
    if (Power) begin
      m_st[d] = M_IDLE;
      for (int k = 0; k < 16; k++) m_tally[d][k] = 0;
      m_total[d] = 0; m_idx[d] = 1; m_best[d] = 0; m_bid[d] = 0; m_tie[d] = 0;
      m_left[d] = 0; m_lock[d] = 0; m_prev[d] = 0; m_out[d] = 0; m_oidx[d] = 0;
      return;
    end
    rise  = (Result && m_prev[d] == 0) ? 1 : 0;
    voted = 0;
    case (m_st[d])
      M_IDLE, M_CLEAR: begin m_out[d] = 0; m_oidx[d] = 0; end
      M_TOTAL:  begin m_out[d] = m_total[d]; m_oidx[d] = 0; end
      M_RESULT: begin m_out[d] = m_tally[d][m_idx[d]]; m_oidx[d] = m_idx[d]; end
      M_WIN:    begin m_out[d] = m_best[d]; m_oidx[d] = m_bid[d]; end
      default: ;
    endcase
    case (m_st[d])
      M_IDLE: begin
        if (Clear) m_st[d] = M_CLEAR;
        else if (Close) m_st[d] = M_CLOSED;
        else if (Ballot && m_lock[d] == 0) m_st[d] = M_ARMED;
        else if (Total) m_st[d] = M_TOTAL;
      end
      M_ARMED: begin
        if (Close) m_st[d] = M_CLOSED;
        else if (id >= 1 && id <= n) begin
          if (m_tally[d][id] < cm) m_tally[d][id]++;
          if (m_total[d] < cm) m_total[d]++;
          voted   = 1;
          m_st[d] = M_IDLE;
        end
      end
      M_TOTAL: begin
        if (Clear) m_st[d] = M_CLEAR;
        else if (Close) m_st[d] = M_CLOSED;
        else if (Ballot) m_st[d] = M_IDLE;
      end
      M_CLOSED: begin
        if (Clear) m_st[d] = M_CLEAR;
        else if (Winner) start_scan(d);
        else if (rise != 0) m_st[d] = M_RESULT;
      end
      M_RESULT: begin
        if (Clear) m_st[d] = M_CLEAR;
        else if (Winner) start_scan(d);
        else if (rise != 0) m_idx[d] = (m_idx[d] % n) + 1;
      end
      M_SCAN: begin
        m_left[d]--;
        if (m_left[d] == 0) m_st[d] = M_WIN;
      end
      M_WIN: begin
        if (Clear) m_st[d] = M_CLEAR;
        else if (rise != 0) m_st[d] = M_RESULT;
      end
      M_CLEAR: begin
        for (int k = 0; k < 16; k++) m_tally[d][k] = 0;
        m_total[d] = 0; m_tie[d] = 0; m_idx[d] = 1;
        if (!Clear) m_st[d] = M_IDLE;
      end
      default: m_st[d] = M_IDLE;
    endcase
    if (voted != 0) m_lock[d] = 1;
    else if (!Ballot) m_lock[d] = 0;
    m_prev[d] = Result ? 1 : 0;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  function automatic int exp_ack(input int d);
    int id;
    id = int'(IN);
    return (m_st[d] == M_ARMED && !Power && !Close && id >= 1 && id <= ncand(d)) ? 1 : 0;
  endfunction

  function automatic int exp_err(input int d);
    return (m_st[d] == M_ARMED && !Power && !Close && int'(IN) > ncand(d)) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("a_out", int'(out_a), m_out[0]);
    check("a_idx", int'(idx_a), m_oidx[0]);
    check("a_ack", int'(ack_a), exp_ack(0));
    check("a_err", int'(err_a), exp_err(0));
    check("a_busy", int'(busy_a), (m_st[0] == M_SCAN) ? 1 : 0);
    check("a_tie", int'(tie_a), (m_st[0] == M_WIN) ? m_tie[0] : 0);
    check("b_out", int'(out_b), m_out[1]);
    check("b_idx", int'(idx_b), m_oidx[1]);
    check("b_ack", int'(ack_b), exp_ack(1));
    check("b_err", int'(err_b), exp_err(1));
    check("b_busy", int'(busy_b), (m_st[1] == M_SCAN) ? 1 : 0);
    check("b_tie", int'(tie_b), (m_st[1] == M_WIN) ? m_tie[1] : 0);
  endtask

  // One clock: compare on the falling edge, then step past the rising edge
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      compare_all();
      if (ack_a)  ack_cnt_a++;
      if (err_a)  err_cnt_a++;
      if (busy_a) busy_cnt_a++;
      if (busy_b) busy_cnt_b++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_vote(input int id);
    IN = 4'(id); Ballot = 1'b1;
    cyc(); cyc();
    Ballot = 1'b0; IN = 4'd0;
    cyc();
  endtask

  task automatic pulse_result();
    Result = 1'b1; cyc();
    Result = 1'b0; cyc(); cyc();
  endtask

  task automatic wait_scan(input string name);
    int w;
    w = 0;
    while ((busy_a || busy_b) && w < 40) begin
      cyc();
      w++;
    end
    check(name, (w < 40) ? 1 : 0, 1);
  endtask

  int base_ack, base_err, base_busy_a, base_busy_b;

  initial begin
    Power = 1'b1; Clear = 1'b0; Close = 1'b0; Ballot = 1'b0;
    Total = 1'b0; Result = 1'b0; Winner = 1'b0; IN = 4'd0;
    cyc(); cyc();
    Power  = 1'b0;
    chk_en = 1'b1;
    cyc();
    check("rst_out_b", int'(out_b), 0);
    check("rst_idx_a", int'(idx_a), 0);
    check("rst_browse_model", m_idx[1], 1);

    // Three votes, then the grand total before close
    base_ack = ack_cnt_a;
    do_vote(3); do_vote(3); do_vote(7);
    check("ack_pulses3", ack_cnt_a - base_ack, 3);
    Total = 1'b1; cyc(); cyc();
    check("total_b", int'(out_b), 3);
    check("total_a", int'(out_a), 3);
    check("total_model", m_total[1], 3);

    // Leave TOTAL via Ballot, which re-arms from IDLE; wait with IN=0, then bad ID
    Total = 1'b0; Ballot = 1'b1; IN = 4'd0;
    cyc(); cyc();
    base_err = err_cnt_a;
    repeat (5) cyc();
    IN = 4'd9;
    repeat (3) cyc();
    check("err_pulses", err_cnt_a - base_err, 3);
    IN = 4'd8; cyc();
    Ballot = 1'b0; IN = 4'd0; cyc();
    check("ack_pulses4", ack_cnt_a - base_ack, 4);
    check("model_t8_a", m_tally[0][8], 1);
    check("model_t9_b", m_tally[1][9], 1);

    // Close while armed; Ballot/Total afterwards must not count
    Ballot = 1'b1; cyc(); cyc();
    Close = 1'b1; cyc();
    Close = 1'b0;
    Ballot = 1'b1; IN = 4'd5; Total = 1'b1; cyc();
    Ballot = 1'b0; Total = 1'b0; cyc();
    Ballot = 1'b1; cyc();
    Ballot = 1'b0; IN = 4'd0; cyc();
    check("closed_total_b", m_total[1], 4);

    // Browse with wrap
    pulse_result();
    check("browse1_idx", int'(idx_b), 1);
    pulse_result(); pulse_result();
    check("browse3_a", int'(out_a), 2);
    check("browse3_b", int'(out_b), 2);
    repeat (4) pulse_result();
    check("browse7_b", int'(out_b), 1);
    check("browse7_idx", int'(idx_b), 7);
    repeat (9) pulse_result();
    check("wrap15_idx_b", int'(idx_b), 1);
    check("wrap15_idx_a", int'(idx_a), 8);
    check("wrap15_out_a", int'(out_a), 1);
    Result = 1'b1; repeat (10) cyc();
    Result = 1'b0; cyc();
    check("held_idx_b", int'(idx_b), 2);
    check("held_idx_a", int'(idx_a), 1);

    // Clear, then winner with a tie
    Clear = 1'b1; cyc(); cyc();
    Clear = 1'b0; cyc(); cyc();
    check("cleared_model", m_total[1], 0);
    repeat (5) do_vote(2);
    repeat (5) do_vote(9);
    repeat (3) do_vote(4);
    Close = 1'b1; cyc();
    Close = 1'b0;
    base_busy_a = busy_cnt_a; base_busy_b = busy_cnt_b;
    Winner = 1'b1; cyc();
    wait_scan("scan1_bound");
    cyc();
    Winner = 1'b0;
    check("busy_len_b", busy_cnt_b - base_busy_b, 15);
    check("busy_len_a", busy_cnt_a - base_busy_a, 8);
    check("win_out_b", int'(out_b), 5);
    check("win_idx_b", int'(idx_b), 2);
    check("win_tie_b", int'(tie_b), 1);
    check("win_out_a", int'(out_a), 5);
    check("win_idx_a", int'(idx_a), 2);
    check("win_tie_a", int'(tie_a), 0);

    // All-zero winner
    Clear = 1'b1; cyc();
    Clear = 1'b0; cyc(); cyc();
    Close = 1'b1; cyc();
    Close = 1'b0; Winner = 1'b1; cyc();
    wait_scan("scan0_bound");
    cyc();
    Winner = 1'b0;
    check("zero_out_b", int'(out_b), 0);
    check("zero_idx_b", int'(idx_b), 0);
    check("zero_tie_b", int'(tie_b), 0);

    // Saturation at CNT_W=3
    Clear = 1'b1; cyc();
    Clear = 1'b0; cyc(); cyc();
    repeat (9) do_vote(1);
    Total = 1'b1; cyc(); cyc();
    check("sat_total_a", int'(out_a), 7);
    check("sat_total_b", int'(out_b), 9);
    Total = 1'b0;
    Close = 1'b1; cyc();
    Close = 1'b0;
    pulse_result();
    check("sat_tally_a", int'(out_a), 7);
    check("sat_idx_a", int'(idx_a), 1);

    // Power in the middle of a scan
    Winner = 1'b1; cyc(); cyc(); cyc();
    check("midscan_busy_b", int'(busy_b), 1);
    Power = 1'b1; cyc();
    Power = 1'b0; Winner = 1'b0;
    check("pwr_out_b", int'(out_b), 0);
    check("pwr_busy_b", int'(busy_b), 0);
    check("pwr_busy_a", int'(busy_a), 0);
    check("pwr_idx_a", int'(idx_a), 0);
    cyc(); cyc();
    check("pwr_state_model", m_st[1], M_IDLE);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/vote_tally_param.md
Name: vote_tally_param

Overview:
Parametrised successor to the team's single-channel ballot machine. Counts one vote per armed ballot across N_CAND candidates with saturating tallies and a sticky poll-close. After close it offers edge-stepped result browsing with wrap-around and a sequential winner/tie scan. It sits between the keypad/button front end and the 7-segment/LED display driver.

Parameters:
N_CAND, 15, number of candidates; valid candidate IDs are 1..N_CAND (2..(2^ID_W)-1)
ID_W, 4, width of candidate ID input IN and index output out_idx
CNT_W, 12, width of each tally, the grand total and out

Ports:
clk  input  1  system clock, all logic on rising edge
Power  input  1  synchronous active-high reset
Clear  input  1  level; wipe all tallies and reopen poll
Close  input  1  level; close the poll (sticky)
Ballot  input  1  level; arm one ballot
Total  input  1  level; display grand total
Result  input  1  step button; rising edge detected internally
Winner  input  1  level; start winner scan (closed poll only)
IN  input  ID_W  candidate ID for the armed ballot; 0 = no selection
out  output  CNT_W  displayed count (registered)
out_idx  output  ID_W  candidate index tied to out; 0 when out is not a per-candidate value
vote_ack  output  1  one-cycle pulse: vote counted
vote_err  output  1  one-cycle pulse: IN nonzero and > N_CAND while armed
busy  output  1  high during winner scan
tie  output  1  valid in WIN state: another candidate equals winner's nonzero count

Behaviour:
- Clock is clk. Reset is Power: synchronous, active-high, and it overrides everything.
- Reset effect: state IDLE; all tallies and total = 0; out = 0; out_idx = 0; browse index = 1; vote_ack, vote_err, busy, tie = 0; Result edge register = 0.
- States: IDLE, ARMED, TOTAL, CLOSED, RESULT, SCAN, WIN, CLEAR. out is updated on the edge after the state is entered (1-cycle latency).
- IDLE: priority Clear > Close > Ballot > Total.
  - Clear -> CLEAR; Close -> CLOSED; Ballot -> ARMED; Total -> TOTAL.
  - Otherwise stay; out = 0, out_idx = 0.
- ARMED: Close has priority and goes to CLOSED with no count (ballot discarded).
  - 1 <= IN <= N_CAND: tally[IN]++ and total++, both saturating at 2^CNT_W-1 (no wrap). vote_ack pulses 1 cycle. -> IDLE.
  - IN > N_CAND: vote_err pulses and the state stays ARMED. Held IN errors every cycle.
  - IN = 0: wait. Exactly one vote per arming; Ballot held after return does not re-arm until it deasserts for at least 1 cycle.
- TOTAL: out = total, out_idx = 0. Close -> CLOSED; Ballot or Clear -> IDLE/CLEAR, with Clear taking priority.
- CLOSED: sticky; Ballot and Total are ignored and no count can change. Only Clear or Power reopens.
  - Clear -> CLEAR.
  - Winner -> SCAN.
  - Result rising edge -> RESULT showing the current browse index (no advance on entry).
- RESULT: out = tally[idx], out_idx = idx.
  - Each later Result rising edge advances idx: N_CAND wraps to 1.
  - A held Result gives exactly one step.
  - Clear -> CLEAR; Winner -> SCAN.
- SCAN: busy = 1; exactly N_CAND cycles, visiting candidates 1..N_CAND.
  - Starts from best_cnt = 0, best_id = 0, tie = 0.
  - tally > best replaces best and clears tie. tally == best and best != 0 sets tie.
  - Inputs other than Power are ignored during the scan.
  - Then -> WIN, busy = 0.
- WIN: out = best_cnt, out_idx = best_id (lowest ID among equals), tie held.
  - All-zero tallies give out = 0, out_idx = 0, tie = 0.
  - Result edge -> RESULT; Clear -> CLEAR.
- CLEAR: in one cycle all tallies, total, out, out_idx and tie = 0, idx = 1. Stays while Clear is high, then -> IDLE.
- vote_ack and vote_err are never high simultaneously. Both are 0 outside ARMED.

Test Plan:
- Reset then Ballot, IN=3; repeat with IN=3 then IN=7 -> vote_ack pulses 3 times. Close, browse: idx3 = 2, idx7 = 1, others 0. Total path before close shows 3.
- Armed with IN=0 for 5 cycles, then IN=9 (N_CAND=8) -> no count, vote_err 1 pulse per cycle. Then IN=8 -> tally[8] = 1, ack.
- Close while armed with IN=0, then Ballot and Total toggled -> state CLOSED, total unchanged. Clear -> total 0, poll reopens.
- RESULT browse with N_CAND=15: 15 Result edges from idx 1 -> returns to idx 1. Result held 10 cycles -> single step.
- Winner with tallies {2:5, 9:5, 4:3} -> busy for exactly N_CAND cycles, then out = 5, out_idx = 2, tie = 1. All-zero case -> 0/0/0.
- CNT_W=3: 9 votes for candidate 1 -> tally = 7 and total = 7 (saturated). Power asserted mid-SCAN -> next cycle all outputs 0, IDLE.
